// File: rtl/router_output_arbiter.sv
// rtl/router_output_arbiter.sv - round-robin owner of one router output port with frame hold, timeout and inter-frame gap
module router_output_arbiter #(
    parameter int N          = 16,
    parameter int MAX_FRAME  = 1024,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         busy_n,
    output logic                 frame_active,
    output logic                 timeout_err,
    output logic [15:0]          frame_cnt
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_FRAME);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [HW-1:0]  hold_cnt;
    logic [GW-1:0]  gap_cnt;

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW:0]   idx;
    logic [IDW-1:0] ptr_next;
    logic [N-1:0]   pick_onehot;
    logic           last_hit;
    logic           timeout_hit;

    // Scan requesters starting at the round-robin pointer, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next    = (pick == IDW'(N-1)) ? '0 : pick + IDW'(1);
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick;
        last_hit    = last[grant_id];
        timeout_hit = (hold_cnt == HW'(MAX_FRAME-1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            grant        <= '0;
            grant_id     <= '0;
            busy_n       <= '1;
            frame_active <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state        <= ST_GRANT;
                        grant        <= pick_onehot;
                        grant_id     <= pick;
                        busy_n       <= pick_onehot;
                        frame_active <= 1'b1;
                        hold_cnt     <= '0;
                        ptr          <= ptr_next;
                    end
                end
                ST_GRANT: begin
                    // A last arriving on the timeout cycle still completes the frame normally.
                    if (last_hit || timeout_hit) begin
                        state        <= ST_GAP;
                        grant        <= '0;
                        busy_n       <= '0;
                        frame_active <= 1'b0;
                        gap_cnt      <= '0;
                        if (last_hit) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES-1)) begin
                        state  <= ST_IDLE;
                        busy_n <= '1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    grant        <= '0;
                    busy_n       <= '1;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb/tb_router_output_arbiter.sv - directed self-checking bench for router_output_arbiter
module tb_router_output_arbiter;

    localparam int N   = 16;
    localparam int MF  = 8;
    localparam int GAP = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N-1:0]  grant;
    logic [3:0]    grant_id;
    logic [N-1:0]  busy_n;
    logic          frame_active;
    logic          timeout_err;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    router_output_arbiter #(.N(N), .MAX_FRAME(MF), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .last         (last),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy_n       (busy_n),
        .frame_active (frame_active),
        .timeout_err  (timeout_err),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        last  = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"},    32'(grant),        32'h0);
        check({tag, "_gid"},      32'(grant_id),     32'h0);
        check({tag, "_busy"},     32'(busy_n),       32'hFFFF);
        check({tag, "_active"},   32'(frame_active), 32'h0);
        check({tag, "_tmo"},      32'(timeout_err),  32'h0);
        check({tag, "_fcnt"},     32'(frame_cnt),    32'h0);
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        last  = '0;

        // 1: single requester, last 4 cycles into the frame, gap enforced
        do_reset();
        check_reset_state("t1_rst");
        req = 16'h0001;
        tick();
        check("t1_grant", 32'(grant), 32'h0001);
        check("t1_gid", 32'(grant_id), 32'h0);
        check("t1_busy", 32'(busy_n), 32'h0001);
        check("t1_active", 32'(frame_active), 32'h1);
        tick(); tick(); tick();
        check("t1_hold", 32'(grant), 32'h0001);
        last = 16'h0001;
        tick();
        last = '0;
        check("t1_drop", 32'(grant), 32'h0);
        check("t1_fcnt", 32'(frame_cnt), 32'h1);
        check("t1_gap_busy", 32'(busy_n), 32'h0);
        check("t1_gap_active", 32'(frame_active), 32'h0);
        tick();
        check("t1_gap2", 32'(grant), 32'h0);
        tick();
        check("t1_idle", 32'(grant), 32'h0);
        check("t1_idle_busy", 32'(busy_n), 32'hFFFF);
        tick();
        check("t1_regrant", 32'(grant), 32'h0001);

        // 2: all requesting, 3-cycle frames -> round robin 0..15,0
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= N; k++) begin
            tick();
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(16'h1 << (k % N)));
            check($sformatf("t2_gid%0d", k), 32'(grant_id), 32'(k % N));
            check($sformatf("t2_busy%0d", k), 32'(busy_n), 32'(16'h1 << (k % N)));
            tick();
            tick();
            last = 16'h1 << (k % N);
            tick();
            last = '0;
            check($sformatf("t2_gapbusy%0d", k), 32'(busy_n), 32'h0);
            check($sformatf("t2_gapgrant%0d", k), 32'(grant), 32'h0);
            tick();
            tick();
        end
        check("t2_fcnt", 32'(frame_cnt), 32'(N + 1));

        // 3: owner 2 never asserts last -> timeout after 8 grant cycles
        do_reset();
        req = 16'h0004;
        tick();
        check("t3_grant", 32'(grant), 32'h0004);
        req = 16'h000C;
        for (int k = 0; k < MF - 1; k++) tick();
        check("t3_hold_last", 32'(grant), 32'h0004);
        check("t3_no_tmo_yet", 32'(timeout_err), 32'h0);
        tick();
        check("t3_drop", 32'(grant), 32'h0);
        check("t3_tmo", 32'(timeout_err), 32'h1);
        check("t3_fcnt", 32'(frame_cnt), 32'h0);
        tick();
        check("t3_tmo_pulse", 32'(timeout_err), 32'h0);
        tick();
        tick();
        check("t3_next", 32'(grant), 32'h0008);
        check("t3_next_id", 32'(grant_id), 32'h3);

        // 4: foreign last ignored, req drop keeps grant, last beats timeout
        do_reset();
        req = 16'h0002;
        tick();
        check("t4_grant", 32'(grant), 32'h0002);
        req  = '0;
        last = 16'h0020;
        tick();
        last = '0;
        check("t4_ignore", 32'(grant), 32'h0002);
        check("t4_ignore_fcnt", 32'(frame_cnt), 32'h0);
        for (int k = 0; k < MF - 2; k++) tick();
        check("t4_still", 32'(grant), 32'h0002);
        last = 16'h0002;
        tick();
        last = '0;
        check("t4_drop", 32'(grant), 32'h0);
        check("t4_fcnt", 32'(frame_cnt), 32'h1);
        check("t4_no_tmo", 32'(timeout_err), 32'h0);

        // 5: reset mid-frame with owner 7
        do_reset();
        req = 16'h0080;
        tick();
        check("t5_grant", 32'(grant), 32'h0080);
        check("t5_gid", 32'(grant_id), 32'h7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("t5_rst");
        req = 16'h0081;
        tick();
        check("t5_ptr0", 32'(grant), 32'h0001);

        // 6: frame counter wraps 0xFFFF -> 0
        do_reset();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        #1;
        check("t6_preload", 32'(frame_cnt), 32'hFFFF);
        req = 16'h0001;
        tick();
        last = 16'h0001;
        tick();
        last = '0;
        check("t6_wrap", 32'(frame_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
